ras_issue: RTL and testbench
============================

# ras_issue

Front-end issue controller for the speculative return-address-stack stage. It accepts call/return events from fetch and drives one stage's `trigger`, `push_i`, `pop_i`, `data_i`, `addr_i` inputs, tracking the speculative top-of-stack pointer. It accepts in-order retirement acknowledgements and converts them into the stage's `commit` pulse. It keeps the committed top-of-stack pointer and bounds in-flight operations to the stage's pending-action capacity.

## Interface

- `DEPTH`, 16: maximum issued-but-uncommitted operations; equals the stage's pending FIFO depth.
- `WIDTH`, 32: return-address width.
- `ADDR_WIDTH`, 10: stack pointer width; pointers wrap modulo 2^ADDR_WIDTH.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: fetch event valid.
- `req_ready` out 1: event accepted when `req_valid && req_ready`.
- `req_push` in 1: call; push `req_data`.
- `req_pop` in 1: return; pop.
- `req_data` in WIDTH: return address for a push.
- `cmt_valid` in 1: oldest issued op retires.
- `cmt_ready` out 1: retirement accepted when `cmt_valid && cmt_ready`.
- `trigger` out 1: to stage `trigger`.
- `push_o` out 1: to stage `push_i`.
- `pop_o` out 1: to stage `pop_i`.
- `data_o` out WIDTH: to stage `data_i`.
- `addr_o` out ADDR_WIDTH: to stage `addr_i`.
- `commit` out 1: to stage `commit`.
- `spec_tos` out ADDR_WIDTH: speculative top-of-stack pointer; fed to the stage `addr` lookup for return prediction.
- `commit_tos` out ADDR_WIDTH: architectural top-of-stack pointer.
- `inflight` out $clog2(DEPTH)+1: issued, uncommitted op count.

## Operation

- Accepted event with push or pop: next cycle `trigger`=1 with registered `push_o`, `pop_o`, `data_o`, `addr_o`.
- `addr_o` and next `spec_tos` depend on the event:
  - Push only: `addr_o = spec_tos+1`, and `spec_tos` becomes `spec_tos+1`.
  - Pop only: `addr_o = spec_tos-1`, and `spec_tos` becomes `spec_tos-1`.
  - Push and pop (tail call, replace): `addr_o = spec_tos`; `spec_tos` is unchanged.
- `data_o`:
  - Equals `req_data` when pushing.
  - Is 0 when not pushing.
- Accepted event with neither push nor pop: consumed silently; no trigger, no state change.
- All pointer arithmetic wraps modulo 2^ADDR_WIDTH; there is no overflow or underflow detection, because the stage handles an empty pop.
- Each issued op is logged as {push, pop} in an op-log FIFO, written when `trigger`=1.
- Retirement: `commit` = `cmt_valid && cmt_ready`, combinational. The log head is popped and applied to `commit_tos`:
  - push only: +1.
  - pop only: -1.
  - both, or neither: no change.
- `inflight`:
  - +1 on each cycle with `trigger`=1.
  - -1 on each cycle with `commit`=1.
  - Simultaneous increment and decrement: unchanged.
- `req_ready = !reset && (inflight + trigger) < DEPTH`.
- `cmt_ready = !reset && inflight != 0`.
- Reset values:
  - `trigger`, `push_o`, `pop_o`, `commit`, `req_ready`, `cmt_ready` = 0.
  - `data_o`, `addr_o`, `spec_tos`, `commit_tos`, `inflight` = 0.
  - Op log emptied.
- Reset mid-operation: all in-flight ops are discarded, and the stage is reset in the same cycle by the shared `reset`.

## Timing

- Accept-to-trigger latency: exactly 1 cycle. `trigger` is high for exactly one cycle per accepted push/pop event.
- `spec_tos` updates at the accept edge, so a back-to-back event sees the updated pointer. One event per cycle is sustainable.
- Earliest commit of an op: the cycle after its trigger cycle, because `inflight` counts it at the trigger edge. The stage FIFO is therefore never pushed and popped while empty.
- `commit_tos` updates at the edge where `commit`=1.
- Full boundary: with `inflight`=DEPTH-1 and `trigger`=1, `req_ready`=0. A commit that cycle does not reopen ready until the next cycle.
- `cmt_valid` while `cmt_ready`=0: ignored, with no side effect; the retirement source holds `cmt_valid`.

## Structure

- Shared package `ras_pkg`:
  - op encoding typedef `ras_op_t` {push, pop}.
  - pointer-delta helper function (+1 / -1 / 0).
- Sub-module: `ras_fifo` for the op log, with WIDTH=2 and DEPTH=DEPTH.
- Remaining logic: one issue register stage plus two counters, in this module.

## Test plan

- After reset: 3 pushes 0x100, 0x104, 0x108.
  - `addr_o` 1, 2, 3 on consecutive trigger cycles.
  - `spec_tos`=3 and `inflight`=3.
  - `commit_tos`=0.
- From `spec_tos`=3: pop, then push+pop with 0x200.
  - `addr_o`=2, then `addr_o`=2 with `data_o`=0x200.
  - `spec_tos`=2.
- Fill: DEPTH=16 pushes with no commits.
  - `req_ready` drops after the 16th accept.
  - One commit restores `req_ready` the following cycle.
  - `commit_tos`=1.
- Wrap: `spec_tos`=0, then a pop.
  - `addr_o`=0x3FF and `spec_tos`=0x3FF.
  - A subsequent push gives `addr_o`=0.
- `cmt_valid` held high from reset, then a single push.
  - `commit` asserts exactly two cycles after accept.
  - Never asserted when `inflight`=0.
- Reset asserted with `inflight`=5.
  - Next cycle: all outputs 0 and `req_ready`=0 while reset is held.
  - `req_ready`=1 the cycle after release.

Source files
------------

// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared op encoding and pointer-delta helper for the RAS issue path
package ras_pkg;

  // One logged stage operation: call pushes, return pops, both means replace
  typedef struct packed {
    logic push;
    logic pop;
  } ras_op_t;

  // Top-of-stack movement caused by one op; replace and no-op leave it alone
  function automatic int ras_delta(input ras_op_t op);
    if (op.push && !op.pop) return 1;
    if (op.pop && !op.push) return -1;
    return 0;
  endfunction

endpackage

// File: rtl/ras_fifo.sv
// rtl/ras_fifo.sv - small synchronous FIFO used as the issued-op log
module ras_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_tvalid,
  input  logic [WIDTH-1:0] wr_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic [WIDTH-1:0] rd_tdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A write into a full log is only taken when the head leaves in the same cycle
  assign do_rd     = rd_tready && (count != '0);
  assign do_wr     = wr_tvalid && ((count != CW'(DEPTH)) || do_rd);
  assign rd_tvalid = (count != '0);
  assign rd_tdata  = mem[rd_ptr];

  // Entry storage; contents are only observed once counted, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_tdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/ras_issue.sv
// rtl/ras_issue.sv - issue/commit controller driving one speculative return-address-stack stage
module ras_issue
  import ras_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_push,
  input  logic                    req_pop,
  input  logic [WIDTH-1:0]        req_data,
  input  logic                    cmt_valid,
  output logic                    cmt_ready,
  output logic                    trigger,
  output logic                    push_o,
  output logic                    pop_o,
  output logic [WIDTH-1:0]        data_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   spec_tos,
  output logic [ADDR_WIDTH-1:0]   commit_tos,
  output logic [$clog2(DEPTH):0]  inflight
);

  localparam int IW = $clog2(DEPTH) + 1;

  ras_op_t     req_op;
  ras_op_t     issued_op;
  ras_op_t     head_op;
  logic        accept;
  logic        issue;
  logic        log_valid;
  logic [IW:0] occupancy;

  assign req_op.push    = req_push;
  assign req_op.pop     = req_pop;
  assign issued_op.push = push_o;
  assign issued_op.pop  = pop_o;

  // The op sitting in the issue register is already committed to the stage,
  // so it counts against capacity before inflight sees it
  assign occupancy = {1'b0, inflight} + (IW + 1)'(trigger);
  assign req_ready = !reset && (occupancy < (IW + 1)'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign issue     = accept && (req_push || req_pop);

  assign cmt_ready = !reset && (inflight != '0) && log_valid;
  assign commit    = cmt_valid && cmt_ready;

  // Issue register: one-cycle registered command to the stage
  always_ff @(posedge clk) begin
    if (reset) begin
      trigger <= 1'b0;
      push_o  <= 1'b0;
      pop_o   <= 1'b0;
      data_o  <= '0;
      addr_o  <= '0;
    end else begin
      trigger <= issue;
      push_o  <= issue && req_push;
      pop_o   <= issue && req_pop;
      data_o  <= (issue && req_push) ? req_data : '0;
      if (issue) addr_o <= spec_tos + ADDR_WIDTH'(ras_delta(req_op));
    end
  end

  // Speculative pointer moves at the accept edge so back-to-back events chain
  always_ff @(posedge clk) begin
    if (reset) spec_tos <= '0;
    else if (issue) spec_tos <= spec_tos + ADDR_WIDTH'(ras_delta(req_op));
  end

  // Architectural pointer follows the retiring head of the op log
  always_ff @(posedge clk) begin
    if (reset) commit_tos <= '0;
    else if (commit) commit_tos <= commit_tos + ADDR_WIDTH'(ras_delta(head_op));
  end

  // Issued-but-uncommitted count, incremented at the trigger edge
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({trigger, commit})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  ras_fifo #(
    .WIDTH (2),
    .DEPTH (DEPTH)
  ) u_op_log (
    .clk       (clk),
    .reset     (reset),
    .wr_tvalid (trigger),
    .wr_tdata  (issued_op),
    .rd_tvalid (log_valid),
    .rd_tready (commit),
    .rd_tdata  (head_op)
  );

endmodule

// File: tb/tb_ras_issue.sv
// tb/tb_ras_issue.sv - scoreboard bench for ras_issue
module tb_ras_issue;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 10;
  localparam int IW    = $clog2(DEPTH) + 1;
  localparam int PMOD  = 1 << AW;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_push;
  logic             req_pop;
  logic [WIDTH-1:0] req_data;
  logic             cmt_valid;
  logic             cmt_ready;
  logic             trigger;
  logic             push_o;
  logic             pop_o;
  logic [WIDTH-1:0] data_o;
  logic [AW-1:0]    addr_o;
  logic             commit;
  logic [AW-1:0]    spec_tos;
  logic [AW-1:0]    commit_tos;
  logic [IW-1:0]    inflight;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          push;
    bit          pop;
    logic [31:0] data;
    int          addr;
  } exp_t;

  exp_t     exp_q[$];
  bit [1:0] m_log[$];
  int       m_spec = 0;
  int       m_commit = 0;
  bit       m_pend = 0;
  bit [1:0] m_pend_op = 2'b00;

  ras_issue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_push   (req_push),
    .req_pop    (req_pop),
    .req_data   (req_data),
    .cmt_valid  (cmt_valid),
    .cmt_ready  (cmt_ready),
    .trigger    (trigger),
    .push_o     (push_o),
    .pop_o      (pop_o),
    .data_o     (data_o),
    .addr_o     (addr_o),
    .commit     (commit),
    .spec_tos   (spec_tos),
    .commit_tos (commit_tos),
    .inflight   (inflight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor + reference model: compare mid-cycle, then advance model to the next edge
  always @(negedge clk) begin
    bit       mr;
    bit       mc;
    bit [1:0] op;
    exp_t     e;
    mr = !reset && ((m_log.size() + int'(m_pend)) < DEPTH);
    mc = !reset && (m_log.size() != 0);
    chk("req_ready", req_ready, mr);
    chk("cmt_ready", cmt_ready, mc);
    chk("commit", commit, cmt_valid && mc);
    chk("trigger", trigger, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (trigger) begin
        chk("push_o", push_o, e.push);
        chk("pop_o", pop_o, e.pop);
        chk("data_o", data_o, e.data);
        chk("addr_o", addr_o, e.addr);
      end
    end
    chk("spec_tos", spec_tos, m_spec);
    chk("commit_tos", commit_tos, m_commit);
    chk("inflight", inflight, m_log.size());

    if (reset) begin
      exp_q.delete();
      m_log.delete();
      m_pend   = 0;
      m_spec   = 0;
      m_commit = 0;
    end else begin
      if (cmt_valid && mc) begin
        op = m_log.pop_front();
        if (op == 2'b10) m_commit = (m_commit + 1) % PMOD;
        if (op == 2'b01) m_commit = (m_commit + PMOD - 1) % PMOD;
      end
      if (m_pend) m_log.push_back(m_pend_op);
      m_pend = 0;
      if (req_valid && mr && (req_push || req_pop)) begin
        e.push = req_push;
        e.pop  = req_pop;
        e.data = req_push ? req_data : 32'h0;
        if (req_push && !req_pop)      m_spec = (m_spec + 1) % PMOD;
        else if (req_pop && !req_push) m_spec = (m_spec + PMOD - 1) % PMOD;
        e.addr = m_spec;
        exp_q.push_back(e);
        m_pend    = 1;
        m_pend_op = {req_push, req_pop};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    req_valid = 1'b0;
    cmt_valid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Present one event, wait for acceptance, return in the trigger cycle
  task automatic issue(input bit p, input bit q, input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_push  = p;
    req_pop   = q;
    req_data  = d;
    #1;
    while (!req_ready && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL issue_wait actual=%0d required=<64", n);
    end
    tick();
    req_valid = 1'b0;
    req_push  = 1'b0;
    req_pop   = 1'b0;
    req_data  = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_push  = 1'b0;
    req_pop   = 1'b0;
    req_data  = '0;
    cmt_valid = 1'b0;

    // three calls from reset
    do_reset(2);
    issue(1, 0, 32'h100);
    chk("t1_addr", addr_o, 1);
    issue(1, 0, 32'h104);
    chk("t1_addr", addr_o, 2);
    issue(1, 0, 32'h108);
    chk("t1_addr", addr_o, 3);
    chk("t1_data", data_o, 32'h108);
    tick();
    chk("t1_spec", spec_tos, 3);
    chk("t1_inflight", inflight, 3);
    chk("t1_commit_tos", commit_tos, 0);

    // return then tail-call replace
    issue(0, 1, 32'hdead);
    chk("t2_pop_addr", addr_o, 2);
    chk("t2_pop_data", data_o, 0);
    issue(1, 1, 32'h200);
    chk("t2_rep_addr", addr_o, 2);
    chk("t2_rep_data", data_o, 32'h200);
    tick();
    chk("t2_spec", spec_tos, 2);

    // fill to capacity, commit in the 16th trigger cycle
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) issue(1, 0, $urandom);
    cmt_valid = 1'b1;
    #1;
    chk("fill_ready_low", req_ready, 0);
    chk("fill_commit", commit, 1);
    tick();
    cmt_valid = 1'b0;
    #1;
    chk("fill_ready_back", req_ready, 1);
    chk("fill_commit_tos", commit_tos, 1);
    chk("fill_inflight", inflight, DEPTH - 1);

    // pointer wrap below zero and back
    do_reset(1);
    issue(0, 1, 32'h55);
    chk("wrap_addr", addr_o, 10'h3ff);
    chk("wrap_spec", spec_tos, 10'h3ff);
    chk("wrap_data", data_o, 0);
    issue(1, 0, 32'h300);
    chk("wrap_push_addr", addr_o, 0);

    // commit latency with cmt_valid held from reset
    do_reset(1);
    cmt_valid = 1'b1;
    #1;
    chk("lat_idle_commit", commit, 0);
    tick();
    issue(1, 0, 32'h400);
    chk("lat_trigger", trigger, 1);
    chk("lat_commit_c1", commit, 0);
    tick();
    chk("lat_commit_c2", commit, 1);
    tick();
    chk("lat_commit_c3", commit, 0);
    chk("lat_commit_tos", commit_tos, 1);
    cmt_valid = 1'b0;

    // reset with five ops in flight
    do_reset(1);
    for (int i = 0; i < 5; i++) issue(1, 0, 32'h500 + i);
    tick();
    chk("rst_inflight_pre", inflight, 5);
    reset     = 1'b1;
    cmt_valid = 1'b1;
    tick();
    chk("rst_trigger", trigger, 0);
    chk("rst_push", push_o, 0);
    chk("rst_pop", pop_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_commit", commit, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cmt_ready", cmt_ready, 0);
    chk("rst_spec", spec_tos, 0);
    chk("rst_commit_tos", commit_tos, 0);
    chk("rst_inflight", inflight, 0);
    tick();
    chk("rst_held_ready", req_ready, 0);
    reset     = 1'b0;
    cmt_valid = 1'b0;
    #1;
    chk("rst_release_ready", req_ready, 1);

    // randomized traffic with a mid-run reset
    tick();
    for (int i = 0; i < 3000; i++) begin
      reset     = (i >= 1500 && i < 1502);
      req_valid = $urandom_range(0, 3) != 0;
      req_push  = $urandom_range(0, 1);
      req_pop   = $urandom_range(0, 1);
      req_data  = $urandom;
      cmt_valid = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      tick();
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    cmt_valid = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
